// File: rtl/sram_model_dp_pkg.sv
// Shared types and constants for the dual-port SRAM model.
//   state_t        : INIT (sweep running) / READY (ports live)
//   COLL_*         : collision-mode encodings for COLLISION_MODE
//   cfg_ok()       : elaboration-time legality check of the parameter set
package sram_model_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  localparam int COLL_READ_FIRST  = 0;
  localparam int COLL_WRITE_FIRST = 1;

  // Latency must be 1 or 2 and the address bus must be able to reach every word.
  function automatic bit cfg_ok(input int depth, input int a_width, input int rd_latency);
    longint cap;
    cap = longint'(1) << a_width;
    return (rd_latency == 1 || rd_latency == 2) && depth > 0 &&
           a_width > 0 && a_width < 32 && cap >= longint'(depth);
  endfunction

endpackage

// File: rtl/sram_model_dp_if.sv
// Port bundle of the dual-port SRAM model.
//   master : write port (WEA/ADDRA/DINA), read request (ENB/ADDRB); sees results
//   slave  : the memory; returns DOUTB/VALIDB, INIT_BUSY, ADDR_ERR
interface sram_model_dp_if #(
  parameter int WIDTH   = 10,
  parameter int A_WIDTH = 11
);
  logic               WEA;
  logic [A_WIDTH-1:0] ADDRA;
  logic [WIDTH-1:0]   DINA;
  logic               ENB;
  logic [A_WIDTH-1:0] ADDRB;
  logic [WIDTH-1:0]   DOUTB;
  logic               VALIDB;
  logic               INIT_BUSY;
  logic               ADDR_ERR;

  modport master (output WEA, ADDRA, DINA, ENB, ADDRB,
                  input  DOUTB, VALIDB, INIT_BUSY, ADDR_ERR);
  modport slave  (input  WEA, ADDRA, DINA, ENB, ADDRB,
                  output DOUTB, VALIDB, INIT_BUSY, ADDR_ERR);
endinterface

// File: rtl/sram_model_dp_init_ctrl.sv
// INIT/READY sequencer for the SRAM model. After reset it sweeps every
// address writing INIT_VALUE, then hands the memory write port to the user.
//   clk, reset                  : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data     : user write request
//   state, init_busy            : current phase
//   mem_we, mem_addr, mem_din   : muxed write port into the array
module sram_init_ctrl
  import sram_model_pkg::*;
#(
  parameter int               DEPTH      = 1920,
  parameter int               WIDTH      = 10,
  parameter int               A_WIDTH    = 11,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output state_t             state,
  output logic               init_busy,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_din
);

  localparam logic [A_WIDTH-1:0] LAST    = A_WIDTH'(DEPTH - 1);
  // One extra bit so DEPTH == 2^A_WIDTH is still representable.
  localparam logic [A_WIDTH:0]   DEPTH_W = (A_WIDTH + 1)'(DEPTH);

  state_t             state_nx;
  logic [A_WIDTH-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == INIT) begin
      cnt_nx = cnt + A_WIDTH'(1);
      if (cnt == LAST) begin
        state_nx = READY;
        cnt_nx   = '0;
      end
    end
  end

  // Sweep owns the write port while INIT; user writes outside the array are dropped.
  always_comb begin
    init_busy = (state == INIT);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_din  = INIT_VALUE;
      end
      READY: begin
        mem_we   = wr_en && ({1'b0, wr_addr} < DEPTH_W);
        mem_addr = wr_addr;
        mem_din  = wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_model_dp.sv
// Simple-dual-port SRAM model (one write port, one read port) for the pixel
// line buffer. Registered read with 1 or 2 cycles latency, selectable
// read-first / write-first collision behaviour, self-clearing init sweep.
//   CLK, reset : clock, synchronous active-high reset
//   bus        : slave side of sram_model_dp_if (write, read, status)
module sram_model_dp
  import sram_model_pkg::*;
#(
  parameter int               DEPTH          = 1920,
  parameter int               WIDTH          = 10,
  parameter int               A_WIDTH        = 11,
  parameter int               RD_LATENCY     = 1,
  parameter int               COLLISION_MODE = COLL_READ_FIRST,
  parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
  input logic            CLK,
  input logic            reset,
  sram_model_dp_if.slave bus
);

  localparam int               STAGES  = RD_LATENCY - 1;
  localparam logic [A_WIDTH:0] DEPTH_W = (A_WIDTH + 1)'(DEPTH);

  generate
    if (!cfg_ok(DEPTH, A_WIDTH, RD_LATENCY)) begin : g_cfg_err
      $error("sram_model_dp: illegal RD_LATENCY or A_WIDTH too small for DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];

  state_t             state;
  logic               init_busy, mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]   mem_din;

  sram_init_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .A_WIDTH(A_WIDTH), .INIT_VALUE(INIT_VALUE)
  ) u_init (
    .clk(CLK), .reset(reset),
    .wr_en(bus.WEA), .wr_addr(bus.ADDRA), .wr_data(bus.DINA),
    .state(state), .init_busy(init_busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
  );

  logic ready, a_ok, b_ok, rd_launch, coll;

  assign ready     = (state == READY);
  assign a_ok      = {1'b0, bus.ADDRA} < DEPTH_W;
  assign b_ok      = {1'b0, bus.ADDRB} < DEPTH_W;
  assign rd_launch = ready & bus.ENB;
  assign coll      = bus.WEA & a_ok & b_ok & (bus.ADDRA == bus.ADDRB);

  always_ff @(posedge CLK) begin
    if (mem_we && !reset) mem[mem_addr] <= mem_din;
  end

  // Stage 0 is the registered array read; later stages only advance when
  // carrying a result, so DOUTB holds between reads.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;

  always_ff @(posedge CLK) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_launch;
      if (rd_launch) begin
        if (!b_ok)
          dat_pipe[0] <= '0;
        else if (coll && COLLISION_MODE == COLL_WRITE_FIRST)
          dat_pipe[0] <= bus.DINA;
        else
          dat_pipe[0] <= mem[bus.ADDRB];  // read-first falls out of the NBA ordering
      end
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  logic addr_err;

  always_ff @(posedge CLK) begin
    if (reset)
      addr_err <= 1'b0;
    else if (ready && ((bus.WEA && !a_ok) || (bus.ENB && !b_ok)))
      addr_err <= 1'b1;
  end

  assign bus.DOUTB     = dat_pipe[STAGES];
  assign bus.VALIDB    = vld_pipe[STAGES];
  assign bus.INIT_BUSY = init_busy;
  assign bus.ADDR_ERR  = addr_err;

endmodule

// File: tb/tb_sram_model_dp.sv
// Bench for sram_model_dp. Two instances share one stimulus stream:
//   dut_a : RD_LATENCY = 1, read-first
//   dut_b : RD_LATENCY = 2, write-first
// Both use INIT_VALUE = 10'h155.
module tb_sram_model_dp;
  import sram_model_pkg::*;

  localparam int         DEPTH   = 1920;
  localparam int         WIDTH   = 10;
  localparam int         A_WIDTH = 11;
  localparam logic [9:0] IV      = 10'h155;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        wea, enb;
  logic [10:0] addra, addrb;
  logic [9:0]  dina;

  sram_model_dp_if #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH)) bus_a ();
  sram_model_dp_if #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH)) bus_b ();

  assign bus_a.WEA = wea;  assign bus_a.ADDRA = addra; assign bus_a.DINA = dina;
  assign bus_a.ENB = enb;  assign bus_a.ADDRB = addrb;
  assign bus_b.WEA = wea;  assign bus_b.ADDRA = addra; assign bus_b.DINA = dina;
  assign bus_b.ENB = enb;  assign bus_b.ADDRB = addrb;

  sram_model_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .A_WIDTH(A_WIDTH), .RD_LATENCY(1),
                  .COLLISION_MODE(COLL_READ_FIRST), .INIT_VALUE(IV))
    dut_a (.CLK(CLK), .reset(reset), .bus(bus_a));

  sram_model_dp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .A_WIDTH(A_WIDTH), .RD_LATENCY(2),
                  .COLLISION_MODE(COLL_WRITE_FIRST), .INIT_VALUE(IV))
    dut_b (.CLK(CLK), .reset(reset), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
  endtask

  // {INIT_BUSY, VALIDB, ADDR_ERR, DOUTB} must be {1,0,0,0} on both instances.
  task automatic check_reset(input string name);
    chk({name, " dut_a"}, {bus_a.INIT_BUSY, bus_a.VALIDB, bus_a.ADDR_ERR, bus_a.DOUTB}, 13'h1000);
    chk({name, " dut_b"}, {bus_b.INIT_BUSY, bus_b.VALIDB, bus_b.ADDR_ERR, bus_b.DOUTB}, 13'h1000);
  endtask

  // Count edges until INIT_BUSY drops while driving junk that must be ignored.
  task automatic wait_ready(input string name);
    int n;
    bit bad;
    n = 0; bad = 0;
    wea = 1'b1; addra = 11'd2000; dina = 10'h3AB; enb = 1'b1; addrb = 11'd2000;
    while (bus_a.INIT_BUSY && n < 4000) begin
      tick();
      n++;
      if (bus_a.VALIDB || bus_b.VALIDB || bus_a.ADDR_ERR || bus_b.ADDR_ERR ||
          bus_a.INIT_BUSY !== bus_b.INIT_BUSY) bad = 1;
    end
    idle();
    chk({name, " edges"}, n, DEPTH);
    chk({name, " quiet"}, 32'(bad), 0);
  endtask

  // Back-to-back reads of addresses 0..n-1. Expected data is either the init
  // word or the ramp written by the streaming test (addr mod 1024).
  task automatic stream_read(input string name, input int n, input bit ramp);
    int bad_a, bad_b;
    logic [9:0] ea, eb;
    bad_a = 0; bad_b = 0;
    for (int k = 0; k <= n + 1; k++) begin
      enb   = (k < n);
      addrb = 11'(k);
      tick();
      if (k < n) begin
        ea = ramp ? 10'(k) : IV;
        if (!(bus_a.VALIDB === 1'b1 && bus_a.DOUTB === ea)) bad_a++;
      end else if (bus_a.VALIDB !== 1'b0) bad_a++;
      if (k >= 1 && k <= n) begin
        eb = ramp ? 10'(k - 1) : IV;
        if (!(bus_b.VALIDB === 1'b1 && bus_b.DOUTB === eb)) bad_b++;
      end else if (bus_b.VALIDB !== 1'b0) bad_b++;
    end
    idle();
    chk({name, " dut_a bad reads"}, bad_a, 0);
    chk({name, " dut_b bad reads"}, bad_b, 0);
  endtask

  typedef struct {
    logic        wea;
    logic [10:0] addra;
    logic [9:0]  dina;
    logic        enb;
    logic [10:0] addrb;
    logic        va;   // dut_a VALIDB after the edge
    logic [9:0]  da;   // dut_a DOUTB
    logic        vb;
    logic [9:0]  db;
    logic        err;  // ADDR_ERR on both
  } vec_t;

  vec_t vt [18];

  initial begin
    //         wea addra     dina    enb addrb     va da       vb db       err
    vt[0]  = '{1, 11'd7,    10'h2A5, 0, 11'd0,    0, 10'h155, 0, 10'h155, 0};
    vt[1]  = '{0, 11'd0,    10'h000, 1, 11'd7,    1, 10'h2A5, 0, 10'h155, 0};
    vt[2]  = '{0, 11'd0,    10'h000, 0, 11'd0,    0, 10'h2A5, 1, 10'h2A5, 0};
    vt[3]  = '{1, 11'd100,  10'h001, 0, 11'd0,    0, 10'h2A5, 0, 10'h2A5, 0};
    vt[4]  = '{1, 11'd100,  10'h3FF, 1, 11'd100,  1, 10'h001, 0, 10'h2A5, 0};
    vt[5]  = '{0, 11'd0,    10'h000, 1, 11'd100,  1, 10'h3FF, 1, 10'h3FF, 0};
    vt[6]  = '{0, 11'd0,    10'h000, 0, 11'd0,    0, 10'h3FF, 1, 10'h3FF, 0};
    vt[7]  = '{1, 11'd1920, 10'h123, 0, 11'd0,    0, 10'h3FF, 0, 10'h3FF, 1};
    vt[8]  = '{0, 11'd0,    10'h000, 1, 11'd1920, 1, 10'h000, 0, 10'h3FF, 1};
    vt[9]  = '{0, 11'd0,    10'h000, 1, 11'd0,    1, 10'h155, 1, 10'h000, 1};
    vt[10] = '{0, 11'd0,    10'h000, 1, 11'd1919, 1, 10'h155, 1, 10'h155, 1};
    vt[11] = '{1, 11'd5,    10'h0AA, 1, 11'd5,    1, 10'h155, 1, 10'h155, 1};
    vt[12] = '{0, 11'd0,    10'h000, 1, 11'd5,    1, 10'h0AA, 1, 10'h0AA, 1};
    vt[13] = '{0, 11'd0,    10'h000, 0, 11'd0,    0, 10'h0AA, 1, 10'h0AA, 1};
    vt[14] = '{0, 11'd0,    10'h000, 0, 11'd0,    0, 10'h0AA, 0, 10'h0AA, 1};
    vt[15] = '{1, 11'd6,    10'h1C3, 1, 11'd7,    1, 10'h2A5, 0, 10'h0AA, 1};
    vt[16] = '{0, 11'd0,    10'h000, 1, 11'd6,    1, 10'h1C3, 1, 10'h2A5, 1};
    vt[17] = '{0, 11'd0,    10'h000, 0, 11'd0,    0, 10'h1C3, 1, 10'h1C3, 1};

    idle();
    reset = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    reset = 1'b0;

    wait_ready("init sweep");
    stream_read("init readback", DEPTH, 1'b0);
    chk("init readback no addr_err", {bus_a.ADDR_ERR, bus_b.ADDR_ERR}, 0);

    // Latency, collision and out-of-range vectors.
    for (int i = 0; i < 18; i++) begin
      wea = vt[i].wea; addra = vt[i].addra; dina = vt[i].dina;
      enb = vt[i].enb; addrb = vt[i].addrb;
      tick();
      chk($sformatf("vec%0d dut_a {valid,err,dout}", i),
          {bus_a.VALIDB, bus_a.ADDR_ERR, bus_a.DOUTB}, {vt[i].va, vt[i].err, vt[i].da});
      chk($sformatf("vec%0d dut_b {valid,err,dout}", i),
          {bus_b.VALIDB, bus_b.ADDR_ERR, bus_b.DOUTB}, {vt[i].vb, vt[i].err, vt[i].db});
    end
    idle();

    // Streaming: full-depth ramp write then gapless full-depth read.
    for (int k = 0; k < DEPTH; k++) begin
      wea = 1'b1; addra = 11'(k); dina = 10'(k);
      tick();
    end
    idle();
    stream_read("stream", DEPTH, 1'b1);

    // Reset with reads in flight.
    enb = 1'b1; addrb = 11'd7;
    tick();
    addrb = 11'd6;
    tick();
    reset = 1'b1;
    addrb = 11'd7;
    tick();
    check_reset("reset mid-op edge1");
    tick();
    check_reset("reset mid-op edge2");
    idle();
    reset = 1'b0;
    wait_ready("sweep after mid-op reset");

    // Reset during the sweep restarts it from address 0.
    tick();
    chk("partial sweep no init", {bus_a.INIT_BUSY, bus_b.INIT_BUSY}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (500) tick();
    chk("mid-sweep busy", {bus_a.INIT_BUSY, bus_b.INIT_BUSY}, 2'b11);
    reset = 1'b1;
    tick();
    check_reset("reset during sweep");
    reset = 1'b0;
    wait_ready("restarted sweep");
    stream_read("reinit readback", 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
